// File: rtl/spixel_pkg.sv
// Shared constants for the superpixel draw queue: FSM encoding, guard length and clip limits.
package spixel_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  // Cycles spent ignoring odone while the draw engine starts up
  localparam int unsigned GUARD_CYCLES = 2;

  localparam int unsigned SPIXEL_X_MAX_DEFAULT = 63;
  localparam int unsigned SPIXEL_Y_MAX_DEFAULT = 47;

  function automatic logic coord_in_range(input int unsigned cx, input int unsigned cy,
                                          input int unsigned xmax, input int unsigned ymax);
    return (cx <= xmax) && (cy <= ymax);
  endfunction

endpackage

// File: rtl/spixel_fifo.sv
// Circular-buffer FIFO holding queued draw requests; pointers wrap naturally at 2**DEPTH_LOG2.
module spixel_fifo #(
  parameter int WIDTH      = 20,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level_q == FULL_LEVEL);
  assign do_push = push && !full;
  assign do_pop  = pop && (level_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign level = level_q;

endmodule

// File: rtl/superpixel_draw_queue.sv
// Request queue and issue FSM for the superpixel draw engine.
// Optional clipping of out-of-range requests is enabled by defining SPIXEL_QUEUE_CLIP_EN.
module superpixel_draw_queue
  import spixel_pkg::*;
#(
  parameter int SPIXEL_X_WIDTH = 6,
  parameter int SPIXEL_Y_WIDTH = 6,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int DEPTH_LOG2     = 4
`ifdef SPIXEL_QUEUE_CLIP_EN
  ,
  parameter int SPIXEL_X_MAX   = SPIXEL_X_MAX_DEFAULT,
  parameter int SPIXEL_Y_MAX   = SPIXEL_Y_MAX_DEFAULT
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPIXEL_X_WIDTH-1:0] req_x,
  input  logic [SPIXEL_Y_WIDTH-1:0] req_y,
  input  logic [COLOR_ID_WIDTH-1:0] req_color,
  input  logic                      req_vld,
  output logic                      req_rdy,
  output logic [SPIXEL_X_WIDTH-1:0] x,
  output logic [SPIXEL_Y_WIDTH-1:0] y,
  output logic [COLOR_ID_WIDTH-1:0] idata,
  output logic                      idata_vld,
  input  logic                      odone,
  output logic                      busy,
  output logic [DEPTH_LOG2:0]       level
`ifdef SPIXEL_QUEUE_CLIP_EN
  ,
  output logic [7:0]                dropped
`endif
);

  localparam int ENTRY_W = SPIXEL_X_WIDTH + SPIXEL_Y_WIDTH + COLOR_ID_WIDTH;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [1:0]         guard_cnt_q;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               issue_start;
  logic [ENTRY_W-1:0] head;

  assign req_rdy = !full;
  assign accept  = req_vld && req_rdy;

`ifdef SPIXEL_QUEUE_CLIP_EN
  logic       in_range;
  logic [7:0] dropped_q;

  assign in_range = coord_in_range(32'(req_x), 32'(req_y), SPIXEL_X_MAX, SPIXEL_Y_MAX);
  assign push     = accept && in_range;

  // Out-of-range requests are handshaken but discarded; the count saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropped_q <= '0;
    end else if (accept && !in_range && (dropped_q != 8'hFF)) begin
      dropped_q <= dropped_q + 8'd1;
    end
  end

  assign dropped = dropped_q;
`else
  assign push = accept;
`endif

  spixel_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({req_x, req_y, req_color}),
    .rdata (head),
    .level (level),
    .full  (full)
  );

  // Head is latched on entry to ISSUE and popped during ISSUE
  assign pop         = (state_q == ST_ISSUE);
  assign issue_start = (state_q == ST_IDLE) && (level != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (level != '0) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_GUARD;
      ST_GUARD: if (guard_cnt_q == 2'(GUARD_CYCLES - 1)) state_d = ST_WAIT;
      ST_WAIT:  if (odone) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      guard_cnt_q <= '0;
      x           <= '0;
      y           <= '0;
      idata       <= '0;
      idata_vld   <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= (state_q == ST_GUARD) ? guard_cnt_q + 2'd1 : 2'd0;
      idata_vld   <= issue_start;
      if (issue_start) begin
        {x, y, idata} <= head;
      end
    end
  end

  assign busy = (state_q != ST_IDLE) || (level != '0);

endmodule

// File: tb/tb_superpixel_draw_queue.sv
// Scoreboard bench for superpixel_draw_queue; clip checks run when SPIXEL_QUEUE_CLIP_EN is defined.
module tb_superpixel_draw_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req_x;
  logic [5:0] req_y;
  logic [7:0] req_color;
  logic       req_vld;
  logic       req_rdy;
  logic [5:0] x;
  logic [5:0] y;
  logic [7:0] idata;
  logic       idata_vld;
  logic       odone;
  logic       busy;
  logic [4:0] level;
`ifdef SPIXEL_QUEUE_CLIP_EN
  logic [7:0] dropped;
`endif

  int tests_run = 0;
  int errors    = 0;
  int issue_cnt = 0;
  int base;
  logic [31:0] exp_q[$];

  superpixel_draw_queue dut (
    .clk       (clk),
    .rst       (rst),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_color (req_color),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .x         (x),
    .y         (y),
    .idata     (idata),
    .idata_vld (idata_vld),
    .odone     (odone),
    .busy      (busy),
    .level     (level)
`ifdef SPIXEL_QUEUE_CLIP_EN
    ,
    .dropped   (dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every issued command is compared against the oldest expected entry
  initial forever begin
    @(negedge clk);
    if (rst && idata_vld) begin
      issue_cnt++;
      if (exp_q.size() == 0) check("unexpected_issue", 32'({x, y, idata}), 32'hFFFF_FFFF);
      else                   check("cmd_order", 32'({x, y, idata}), exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] px, input logic [5:0] py, input logic [7:0] pc,
                      input logic exp_rdy, input logic exp_issue);
    req_x     = px;
    req_y     = py;
    req_color = pc;
    req_vld   = 1'b1;
    check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    if (exp_rdy && exp_issue) exp_q.push_back(32'({px, py, pc}));
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!idata_vld && n < 100) begin
      tick();
      n++;
    end
    if (!idata_vld) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic complete(input int gap);
    repeat (gap) tick();
    odone = 1'b1;
    tick();
    odone = 1'b0;
  endtask

  // ISSUE -> GUARD -> GUARD -> WAIT takes three edges before odone is honoured
  task automatic serve_one();
    wait_vld();
    complete(3);
  endtask

  initial begin
    rst = 1'b0; req_x = '0; req_y = '0; req_color = '0; req_vld = 1'b0; odone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(req_rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_vld", 32'(idata_vld), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_rdy", 32'(req_rdy), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_level", 32'(level), 32'd0);

    // Single request
    base = issue_cnt;
    push(6'd5, 6'd7, 8'h1C, 1'b1, 1'b1);
    check("t1_level", 32'(level), 32'd1);
    check("t1_vld_early", 32'(idata_vld), 32'd0);
    tick();
    check("t1_vld", 32'(idata_vld), 32'd1);
    check("t1_x", 32'(x), 32'd5);
    check("t1_y", 32'(y), 32'd7);
    check("t1_idata", 32'(idata), 32'h1C);
    tick();
    check("t1_vld_once", 32'(idata_vld), 32'd0);
    check("t1_level_pop", 32'(level), 32'd0);
    tick();
    tick();
    check("t1_busy_wait", 32'(busy), 32'd1);
    check("t1_x_hold", 32'({x, y, idata}), 32'({6'd5, 6'd7, 8'h1C}));
    odone = 1'b1;
    tick();
    odone = 1'b0;
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_issues", 32'(issue_cnt - base), 32'd1);

    // Fill: one command goes in flight, sixteen more fill the queue
    base = issue_cnt;
    for (int i = 0; i < 17; i++) push(6'(i), 6'(i + 3), 8'(8'h40 + i), 1'b1, 1'b1);
    check("t2_level_full", 32'(level), 32'd16);
    check("t2_rdy_full", 32'(req_rdy), 32'd0);
    push(6'd63, 6'd63, 8'hFF, 1'b0, 1'b0);
    check("t2_level_refused", 32'(level), 32'd16);
    complete(0);
    check("t2_rdy_idle_full", 32'(req_rdy), 32'd0);
    tick();
    check("t2_vld_full", 32'(idata_vld), 32'd1);
    check("t2_rdy_popcycle", 32'(req_rdy), 32'd0);
    check("t2_level_popcycle", 32'(level), 32'd16);
    tick();
    check("t2_rdy_after_pop", 32'(req_rdy), 32'd1);
    check("t2_level_after_pop", 32'(level), 32'd15);
    complete(2);
    for (int i = 0; i < 15; i++) serve_one();
    check("t2_level_empty", 32'(level), 32'd0);
    check("t2_issues", 32'(issue_cnt - base), 32'd17);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // odone during GUARD and IDLE must be ignored
    base = issue_cnt;
    push(6'd2, 6'd3, 8'h33, 1'b1, 1'b1);
    wait_vld();
    tick();
    odone = 1'b1;
    tick();
    tick();
    odone = 1'b0;
    check("t3_busy_after_guard", 32'(busy), 32'd1);
    repeat (5) tick();
    check("t3_busy_wait", 32'(busy), 32'd1);
    check("t3_issues_wait", 32'(issue_cnt - base), 32'd1);
    complete(0);
    check("t3_busy_done", 32'(busy), 32'd0);
    odone = 1'b1;
    repeat (3) tick();
    odone = 1'b0;
    check("t3_busy_idle_odone", 32'(busy), 32'd0);
    check("t3_issues_idle", 32'(issue_cnt - base), 32'd1);
    push(6'd9, 6'd4, 8'h5A, 1'b1, 1'b1);
    serve_one();
    check("t3_issues_final", 32'(issue_cnt - base), 32'd2);

    // Reset in WAIT with three entries queued
    base = issue_cnt;
    for (int i = 0; i < 4; i++) push(6'(10 + i), 6'(20 + i), 8'(8'h90 + i), 1'b1, 1'b1);
    tick();
    check("t4_level3", 32'(level), 32'd3);
    check("t4_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t4_async_level", 32'(level), 32'd0);
    check("t4_async_vld", 32'(idata_vld), 32'd0);
    check("t4_async_busy", 32'(busy), 32'd0);
    check("t4_async_rdy", 32'(req_rdy), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    odone = 1'b1;
    tick();
    odone = 1'b0;
    repeat (10) tick();
    check("t4_no_issue", 32'(issue_cnt - base), 32'd1);
    check("t4_busy_idle", 32'(busy), 32'd0);

    // Push coinciding with pop at level 4, then stream past the pointer wrap
    base = issue_cnt;
    for (int i = 0; i < 5; i++) push(6'(i + 30), 6'(i + 1), 8'($urandom_range(255)), 1'b1, 1'b1);
    check("t5_level4", 32'(level), 32'd4);
    complete(0);
    tick();
    check("t5_vld", 32'(idata_vld), 32'd1);
    check("t5_level_pre", 32'(level), 32'd4);
    push(6'd40, 6'd41, 8'hC3, 1'b1, 1'b1);
    check("t5_level_simul", 32'(level), 32'd4);
    complete(2);
    for (int i = 0; i < 14; i++) begin
      serve_one();
      push(6'(i + 1), 6'(50 - i), 8'($urandom_range(255)), 1'b1, 1'b1);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) serve_one();
    check("t5_level_end", 32'(level), 32'd0);
    check("t5_busy_end", 32'(busy), 32'd0);
    check("t5_issues", 32'(issue_cnt - base), 32'd20);

`ifdef SPIXEL_QUEUE_CLIP_EN
    base = issue_cnt;
    check("clip_drop0", 32'(dropped), 32'd0);
    push(6'd63, 6'd48, 8'hAA, 1'b1, 1'b0);
    repeat (4) tick();
    check("clip_dropped", 32'(dropped), 32'd1);
    check("clip_level", 32'(level), 32'd0);
    check("clip_busy", 32'(busy), 32'd0);
    check("clip_no_issue", 32'(issue_cnt - base), 32'd0);
    push(6'd63, 6'd47, 8'hBB, 1'b1, 1'b1);
    serve_one();
    check("clip_issue", 32'(issue_cnt - base), 32'd1);
    check("clip_dropped_hold", 32'(dropped), 32'd1);
`endif

    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/superpixel_draw_queue.md
SUPERPIXEL_DRAW_QUEUE -- requirements
Module: superpixel_draw_queue

Interface
REQ-001 SHALL have parameter SPIXEL_X_WIDTH, default 6: superpixel column width.
REQ-002 SHALL have parameter SPIXEL_Y_WIDTH, default 6: superpixel row width.
REQ-003 SHALL have parameter COLOR_ID_WIDTH, default 8: colour index width.
REQ-004 SHALL have parameter DEPTH_LOG2, default 4: the queue holds 2**DEPTH_LOG2 entries.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have ports req_x / req_y  input  SPIXEL_X_WIDTH / SPIXEL_Y_WIDTH  superpixel coordinates of a request.
REQ-008 SHALL have port req_color  input  COLOR_ID_WIDTH  colour index of a request.
REQ-009 SHALL have port req_vld  input  1  a request is offered this cycle.
REQ-010 SHALL have port req_rdy  output  1  the queue can accept a request (high when not full).
REQ-011 SHALL have ports x / y / idata  output  as above  command to the superpixel draw engine.
REQ-012 SHALL have port idata_vld  output  1  one-cycle command strobe to the draw engine.
REQ-013 SHALL have port odone  input  1  completion pulse from the draw engine.
REQ-014 SHALL have port busy  output  1  a command is in flight or the queue is non-empty.
REQ-015 SHALL have port level  output  DEPTH_LOG2+1  current queue occupancy.

Function
REQ-016 SHALL accept a request on a cycle with req_vld and req_rdy both high; otherwise the request is ignored.
REQ-017 SHALL store requests in FIFO order, with circular read/write pointers that wrap from 2**DEPTH_LOG2-1 to 0.
REQ-018 SHALL drive req_rdy low when level equals 2**DEPTH_LOG2.
REQ-019 SHALL, on a simultaneous accept and issue-pop, leave level unchanged; at full, a pop in the same cycle does not raise req_rdy until the next cycle.
REQ-020 SHALL implement the FSM IDLE -> ISSUE -> GUARD -> WAIT -> IDLE.
REQ-021 SHALL leave IDLE when level is nonzero; ISSUE pops the head entry, drives x/y/idata from it, and holds idata_vld high for exactly one cycle.
REQ-022 SHALL hold x/y/idata stable from ISSUE until the following odone.
REQ-023 SHALL spend exactly 2 cycles in GUARD, ignoring odone, to mask the draw engine's start-up latency.
REQ-024 SHALL return from WAIT to IDLE on the first odone pulse; odone outside WAIT is ignored.
REQ-025 SHALL allow a back-to-back issue: an entry present when WAIT exits is issued 2 cycles after the odone cycle (IDLE then ISSUE).
REQ-026 SHALL never have more than one command outstanding.
REQ-027 SHALL drive busy = (state != IDLE) or (level != 0).

Reset
REQ-028 SHALL, on rst low, immediately clear pointers, level, FSM (IDLE), x, y, idata, idata_vld, and dropped count, regardless of clock.
REQ-029 SHALL drive req_rdy high, busy low and level 0 throughout reset and in the first cycle after release.
REQ-030 SHALL, on reset mid-command, discard the in-flight command and all queued entries; a later stale odone is ignored because the FSM is in IDLE.

Configuration
REQ-031 SHALL, with SPIXEL_QUEUE_CLIP_EN defined, take parameters SPIXEL_X_MAX (default 63) and SPIXEL_Y_MAX (default 47).
REQ-032 SHALL, with SPIXEL_QUEUE_CLIP_EN defined, drop any accepted request with req_x > SPIXEL_X_MAX or req_y > SPIXEL_Y_MAX; a dropped request is still handshaken but never enqueued.
REQ-033 SHALL, with SPIXEL_QUEUE_CLIP_EN defined, count drops on an output dropped (8 bits) that saturates at 255.
REQ-034 SHALL, without SPIXEL_QUEUE_CLIP_EN, enqueue all accepted requests and have no dropped port.

Structure
REQ-035 SHALL take its FSM state encoding, guard length (2), and default superpixel limits from the shared package spixel_pkg.
REQ-036 SHALL put queue storage and pointers in one sub-module, spixel_fifo; the FSM stays in the top module.

Verification
REQ-037 SHALL verify: a single request (5,7,0x1C) -> idata_vld pulses once 2 cycles later with x=5, y=7, idata=0x1C; busy drops the cycle after odone.
REQ-038 SHALL verify: 16 requests with the engine stalled -> level=16 and req_rdy=0; a 17th request is refused; after 16 odone pulses, commands were issued in order and level=0.
REQ-039 SHALL verify: an odone injected in the GUARD cycles or in IDLE -> no state change and no extra issue.
REQ-040 SHALL verify: rst asserted in WAIT with 3 entries queued -> level=0, idata_vld=0, busy=0 asynchronously; a later odone produces no issue.
REQ-041 SHALL verify: simultaneous push and pop at level 4 -> level stays 4, and pointers wrap correctly after 20 transactions.
REQ-042 SHALL verify, with SPIXEL_QUEUE_CLIP_EN: request (63,48) -> dropped=1, no issue; request (63,47) -> issued.
